// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front-end.
// Keypad FSM encoding and key index helper.
package microwave_pkg;

   localparam int NUM_KEYS         = 10;
   localparam int DEFAULT_DEBOUNCE = 16;

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } kp_state_t;

   function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] k);
      key_index = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (k[i]) key_index = 4'(i);
      end
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-sample debounce and falling-edge pulse
// for a single button or switch channel.
module button_debouncer #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RST_VAL         = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             level_d1_q;
   logic             pulse_q;

   // Sync flops start at the idle level so a release from reset
   // never looks like a press.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q    <= RST_VAL;
         sync2_q    <= RST_VAL;
         cnt_q      <= '0;
         level_q    <= RST_VAL;
         level_d1_q <= RST_VAL;
         pulse_q    <= 1'b0;
      end else begin
         sync1_q    <= raw_i;
         sync2_q    <= sync1_q;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         level_d1_q <= level_q;
         pulse_q    <= level_d1_q & ~level_q;
      end
   end

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_W'(DEBOUNCE_CYCLES)) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/microwave_input_conditioner.sv
// Keypad/button conditioning front-end for the microwave controller:
// synchronised, debounced levels plus single-cycle strobes.
module microwave_input_conditioner
   import microwave_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] keypad_raw,
   input  logic                startn_raw,
   input  logic                stopn_raw,
   input  logic                clearn_raw,
   input  logic                door_closed_raw,
   output logic [NUM_KEYS-1:0] keypad,
   output logic [3:0]          key_code,
   output logic                key_strobe,
   output logic                startn,
   output logic                stopn,
   output logic                clearn,
   output logic                door_closed,
   output logic                start_pulse,
   output logic                stop_pulse,
   output logic                clear_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic door_pulse_unused;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_start (
      .clk(clk), .resetn(resetn), .raw_i(startn_raw),
      .level_o(startn), .pulse_o(start_pulse)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_stop (
      .clk(clk), .resetn(resetn), .raw_i(stopn_raw),
      .level_o(stopn), .pulse_o(stop_pulse)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_clear (
      .clk(clk), .resetn(resetn), .raw_i(clearn_raw),
      .level_o(clearn), .pulse_o(clear_pulse)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_door (
      .clk(clk), .resetn(resetn), .raw_i(door_closed_raw),
      .level_o(door_closed), .pulse_o(door_pulse_unused)
   );

   logic [NUM_KEYS-1:0] kp_s1_q, kp_s2_q;
   kp_state_t           state_q, state_d;
   logic [NUM_KEYS-1:0] cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_KEYS-1:0] keypad_q, keypad_d;
   logic [3:0]          code_q, code_d;
   logic                strobe_q, strobe_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kp_s1_q  <= '0;
         kp_s2_q  <= '0;
         state_q  <= IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         keypad_q <= '0;
         code_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         kp_s1_q  <= keypad_raw;
         kp_s2_q  <= kp_s1_q;
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         keypad_q <= keypad_d;
         code_q   <= code_d;
         strobe_q <= strobe_d;
      end
   end

   // The capture/first-zero sample counts as the first stable one,
   // so the debounce states finish after DEBOUNCE_CYCLES-1 more.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      keypad_d = keypad_q;
      code_d   = code_q;
      strobe_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ($onehot(kp_s2_q)) begin
               cand_d  = kp_s2_q;
               cnt_d   = '0;
               state_d = DEB_PRESS;
            end
         end
         DEB_PRESS: begin
            if (kp_s2_q != cand_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
               state_d  = PRESSED;
               keypad_d = cand_q;
               code_d   = key_index(cand_q);
               strobe_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (kp_s2_q == '0) begin
               cnt_d   = '0;
               state_d = DEB_RELEASE;
            end
         end
         DEB_RELEASE: begin
            if (kp_s2_q != '0) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
               state_d  = IDLE;
               keypad_d = '0;
               code_d   = '0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign keypad     = keypad_q;
   assign key_code   = code_q;
   assign key_strobe = strobe_q;

endmodule
